framebuf_pingpong: RTL and testbench
====================================

FRAMEBUF_PINGPONG -- requirements
Module: framebuf_pingpong

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 12, word address width; each bank holds 2**ADDR_W words.
REQ-003 SHALL have ports, in order:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- s_address  in  ADDR_W  CPU word address into the back bank.
- s_byteenable  in  DATA_W/8  CPU byte lane enables.
- s_chipselect  in  1  CPU access qualifier.
- s_write  in  1  CPU write strobe.
- s_read  in  1  CPU read strobe.
- s_writedata  in  DATA_W  CPU write data.
- s_readdata  out  DATA_W  CPU read data.
- s_readdatavalid  out  1  s_readdata valid.
- s_waitrequest  out  1  CPU access stalled.
- swap_req  in  1  request front/back exchange.
- frame_start  in  1  scan-out frame boundary strobe.
- scan_en  in  1  scan read strobe.
- scan_addr  in  ADDR_W  scan word address into the front bank.
- scan_data  out  DATA_W  scan read data.
- scan_valid  out  1  scan_data valid.
- front_sel  out  1  index of the bank currently displayed.
- swap_done  out  1  one-cycle pulse when front_sel toggles.

Function
REQ-004 SHALL contain two banks of 2**ADDR_W x DATA_W; bank front_sel is read by scan, bank ~front_sel is accessed by the CPU.
REQ-005 SHALL accept a CPU access when s_chipselect=1 and s_waitrequest=0; target bank is ~front_sel as registered at the start of that cycle.
REQ-006 SHALL update only the byte lanes with s_byteenable=1 on an accepted write; byteenable=0 changes nothing.
REQ-007 SHALL return accepted CPU read data with s_readdatavalid=1 exactly 1 cycle after acceptance, including when a swap occurs in between.
REQ-008 SHALL treat s_read and s_write both high as a write only, with no readdatavalid.
REQ-009 SHALL return scan_data with scan_valid=1 exactly 1 cycle after scan_en=1, from the bank that was front in the scan_en cycle.
REQ-010 SHALL implement states IDLE, PENDING (and CLEAR, see REQ-016).
- IDLE -> PENDING on swap_req.
- PENDING -> toggle front_sel on frame_start.
- swap_req in PENDING is absorbed, with no double swap.
REQ-011 SHALL swap in the same cycle when swap_req and frame_start are both high in IDLE.
REQ-012 SHALL toggle front_sel on the clock edge following the qualifying frame_start and pulse swap_done for that same cycle.
REQ-013 SHALL ignore frame_start in IDLE; front_sel is unchanged.

Reset
REQ-014 SHALL on reset force state=IDLE, front_sel=0, swap_done=0, s_readdatavalid=0, scan_valid=0, s_waitrequest=0, s_readdata=0, scan_data=0, and discard in-flight reads.
REQ-015 SHALL leave bank contents unchanged by reset, with undefined power-up contents; reset asserted mid-CLEAR aborts the clear.

Configuration
REQ-016 SHALL, when macro FRAMEBUF_CLEAR_ON_SWAP_EN is defined, enter state CLEAR on each swap.
- CLEAR writes zero to the new back bank, addresses 0 to 2**ADDR_W-1, one word per cycle.
- s_waitrequest=1 for the whole clear; scan reads are unaffected.
- CLEAR returns to IDLE after the last address, or to PENDING if swap_req arrived during CLEAR.
- frame_start during CLEAR does not swap.
REQ-017 SHALL, without FRAMEBUF_CLEAR_ON_SWAP_EN, omit the CLEAR state and tie s_waitrequest to 0.

Verification
REQ-018 SHALL cover: write 0xBEEF to address 0x005, read address 0x005 -> s_readdatavalid 1 cycle later with 0xBEEF; scan of address 0x005 does not return 0xBEEF before a swap.
REQ-019 SHALL cover: write 0x1234 with byteenable=2'b10 over 0xBEEF -> read returns 0x12EF.
REQ-020 SHALL cover swapping:
- swap_req, then 3 idle cycles, then frame_start -> front_sel 0->1 and swap_done pulse.
- Scan of address 0x005 then returns 0xBEEF.
- A second swap_req while PENDING yields one toggle only.
REQ-021 SHALL cover: swap_req and frame_start in the same cycle -> toggle next edge; frame_start alone -> no toggle.
REQ-022 SHALL cover: reset asserted in PENDING with a CPU read in flight -> front_sel=0, state IDLE, no s_readdatavalid.
REQ-023 SHALL cover, with FRAMEBUF_CLEAR_ON_SWAP_EN and ADDR_W=4:
- A swap holds s_waitrequest high for 16 cycles.
- All 16 back-bank words then read 0.

Source files
------------

// File: rtl/framebuf_pingpong.sv
// framebuf_pingpong: double-buffered frame store. The scan port reads the front bank
// and the CPU port reads and writes the back bank. A swap request is held until the
// next frame_start, and then the two banks exchange roles.
// Optional feature: define FRAMEBUF_CLEAR_ON_SWAP_EN to zero the new back bank after
// each swap. The CPU is stalled through s_waitrequest while that happens.
module framebuf_pingpong #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_chipselect,
    input  logic                s_write,
    input  logic                s_read,
    input  logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    output logic                s_waitrequest,
    input  logic                swap_req,
    input  logic                frame_start,
    input  logic                scan_en,
    input  logic [ADDR_W-1:0]   scan_addr,
    output logic [DATA_W-1:0]   scan_data,
    output logic                scan_valid,
    output logic                front_sel,
    output logic                swap_done
);
    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, CLEAR = 2'd2} state_t;
    logic [ADDR_W-1:0] clear_addr_reg, clear_addr_next;
    logic              pend_reg, pend_next;
    logic              clear_active;
`else
    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;
`endif

    state_t state_reg, state_next;
    logic   front_sel_reg, front_sel_next;
    logic   swap_fire;
    logic   swap_done_reg, readdatavalid_reg, scan_valid_reg;

    logic              cpu_accept, cpu_wr, cpu_rd;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LANES-1:0]  wr_be;
    wire  [DATA_W-1:0] cpu_rd_word;
    wire  [DATA_W-1:0] scan_rd_word;

`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
    assign clear_active  = (state_reg == CLEAR);
    assign s_waitrequest = clear_active;
`else
    assign s_waitrequest = 1'b0;
`endif

    // When read and write are both asserted, the access is treated as a write only.
    assign cpu_accept = s_chipselect && !s_waitrequest;
    assign cpu_wr     = cpu_accept && s_write;
    assign cpu_rd     = cpu_accept && s_read && !s_write;

    // Back-bank write port. It is shared between CPU writes and the clear sweep.
    // Writes are suppressed while reset is high, so a reset aborts a clear at once.
    always_comb begin
        wr_en   = cpu_wr && !reset;
        wr_addr = s_address;
        wr_data = s_writedata;
        wr_be   = s_byteenable;
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
        if (clear_active) begin
            wr_en   = !reset;
            wr_addr = clear_addr_reg;
            wr_data = '0;
            wr_be   = '1;
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] bank0_mem [DEPTH];
            logic [7:0] bank1_mem [DEPTH];
            logic [7:0] cpu_rd_reg;
            logic [7:0] scan_rd_reg;

            // Byte-lane write. The back bank is the one that is not at front_sel.
            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi] && front_sel_reg)
                    bank0_mem[wr_addr] <= wr_data[gi*8 +: 8];
                if (wr_en && wr_be[gi] && !front_sel_reg)
                    bank1_mem[wr_addr] <= wr_data[gi*8 +: 8];
            end

            // Registered CPU read from the back bank.
            always_ff @(posedge clk) begin
                if (reset)
                    cpu_rd_reg <= '0;
                else if (cpu_rd)
                    cpu_rd_reg <= front_sel_reg ? bank0_mem[s_address] : bank1_mem[s_address];
            end

            // Registered scan read from the front bank.
            always_ff @(posedge clk) begin
                if (reset)
                    scan_rd_reg <= '0;
                else if (scan_en)
                    scan_rd_reg <= front_sel_reg ? bank1_mem[scan_addr] : bank0_mem[scan_addr];
            end

            assign cpu_rd_word[gi*8 +: 8]  = cpu_rd_reg;
            assign scan_rd_word[gi*8 +: 8] = scan_rd_reg;
        end
    endgenerate

    // Swap FSM next-state logic. A request waits in PENDING for a frame boundary.
    always_comb begin
        state_next     = state_reg;
        front_sel_next = front_sel_reg;
        swap_fire      = 1'b0;
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
        clear_addr_next = clear_addr_reg;
        pend_next       = pend_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (swap_req && frame_start)
                    swap_fire = 1'b1;
                else if (swap_req)
                    state_next = PENDING;
            end
            PENDING: begin
                if (frame_start)
                    swap_fire = 1'b1;
            end
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
            CLEAR: begin
                if (swap_req)
                    pend_next = 1'b1;
                clear_addr_next = clear_addr_reg + 1'b1;
                if (clear_addr_reg == {ADDR_W{1'b1}}) begin
                    state_next = (pend_reg || swap_req) ? PENDING : IDLE;
                    pend_next  = 1'b0;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        if (swap_fire) begin
            front_sel_next = ~front_sel_reg;
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
            state_next      = CLEAR;
            clear_addr_next = '0;
            pend_next       = 1'b0;
`else
            state_next      = IDLE;
`endif
        end
    end

    // Control registers: FSM state, front bank index, and the valid and done strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            front_sel_reg     <= 1'b0;
            swap_done_reg     <= 1'b0;
            readdatavalid_reg <= 1'b0;
            scan_valid_reg    <= 1'b0;
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
            clear_addr_reg    <= '0;
            pend_reg          <= 1'b0;
`endif
        end else begin
            state_reg         <= state_next;
            front_sel_reg     <= front_sel_next;
            swap_done_reg     <= swap_fire;
            readdatavalid_reg <= cpu_rd;
            scan_valid_reg    <= scan_en;
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
            clear_addr_reg    <= clear_addr_next;
            pend_reg          <= pend_next;
`endif
        end
    end

    assign s_readdata      = cpu_rd_word;
    assign s_readdatavalid = readdatavalid_reg;
    assign scan_data       = scan_rd_word;
    assign scan_valid      = scan_valid_reg;
    assign front_sel       = front_sel_reg;
    assign swap_done       = swap_done_reg;

endmodule

// File: tb/tb_framebuf_pingpong.sv
// tb_framebuf_pingpong: directed stimulus for framebuf_pingpong.
// A bank-level reference model is checked against the DUT on every cycle, and literal
// expectations pin the model at key points.
// When FRAMEBUF_CLEAR_ON_SWAP_EN is defined, the bench uses ADDR_W=4 and checks the clear sweep.
module tb_framebuf_pingpong;
`ifdef FRAMEBUF_CLEAR_ON_SWAP_EN
    localparam int AW  = 4;
    localparam bit CLR = 1'b1;
`else
    localparam int AW  = 12;
    localparam bit CLR = 1'b0;
`endif
    localparam int DW    = 16;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          reset;
    logic [AW-1:0] s_address;
    logic [1:0]    s_byteenable;
    logic          s_chipselect, s_write, s_read;
    logic [DW-1:0] s_writedata, s_readdata;
    logic          s_readdatavalid, s_waitrequest;
    logic          swap_req, frame_start, scan_en;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_data;
    logic          scan_valid, front_sel, swap_done;

    int checks = 0;
    int errors = 0;

    framebuf_pingpong #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .s_address(s_address), .s_byteenable(s_byteenable),
        .s_chipselect(s_chipselect), .s_write(s_write), .s_read(s_read),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .s_waitrequest(s_waitrequest),
        .swap_req(swap_req), .frame_start(frame_start),
        .scan_en(scan_en), .scan_addr(scan_addr), .scan_data(scan_data),
        .scan_valid(scan_valid), .front_sel(front_sel), .swap_done(swap_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Banks are plain arrays. A word is "known" once the bench has fully defined it.
    // m_pend means that a swap is owed. m_clr counts the clear words still to write.
    logic [DW-1:0] m_mem   [2][DEPTH];
    bit            m_known [2][DEPTH];
    bit            m_front, m_pend, m_swap_done, m_rdv, m_sv, m_ready;
    bit            m_rd_known, m_sd_known;
    int            m_clr;
    logic [DW-1:0] m_rd, m_sd;

    initial begin
        m_ready = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++)
                m_known[b][i] = 1'b0;
    end

    always @(posedge clk) begin : model
        bit stall, back, fire;
        if (reset) begin
            m_front = 1'b0; m_pend = 1'b0; m_clr = 0; m_swap_done = 1'b0;
            m_rdv = 1'b0; m_sv = 1'b0; m_rd = '0; m_sd = '0;
            m_rd_known = 1'b1; m_sd_known = 1'b1; m_ready = 1'b1;
        end else begin
            stall = (m_clr > 0);
            back  = !m_front;
            m_rdv = s_chipselect && !stall && s_read && !s_write;
            if (m_rdv) begin
                m_rd       = m_mem[back][s_address];
                m_rd_known = m_known[back][s_address];
            end
            m_sv = scan_en;
            if (scan_en) begin
                m_sd       = m_mem[m_front][scan_addr];
                m_sd_known = m_known[m_front][scan_addr];
            end
            if (s_chipselect && !stall && s_write) begin
                for (int b = 0; b < DW / 8; b++)
                    if (s_byteenable[b])
                        m_mem[back][s_address][b*8 +: 8] = s_writedata[b*8 +: 8];
                m_known[back][s_address] = m_known[back][s_address] || (s_byteenable == 2'b11);
            end
            fire = 1'b0;
            if (m_clr > 0) begin
                m_mem[back][DEPTH - m_clr]   = '0;
                m_known[back][DEPTH - m_clr] = 1'b1;
                m_clr = m_clr - 1;
                if (swap_req) m_pend = 1'b1;
            end else begin
                fire = frame_start && (m_pend || swap_req);
                if (fire) begin
                    m_front = !m_front;
                    m_pend  = 1'b0;
                    m_clr   = CLR ? DEPTH : 0;
                end else if (swap_req) begin
                    m_pend = 1'b1;
                end
            end
            m_swap_done = fire;
        end
    end

    // Per-cycle comparison of the DUT outputs against the model, made between clock edges.
    always @(posedge clk) begin
        #2;
        if (m_ready) begin
            check("front_sel", front_sel, m_front);
            check("swap_done", swap_done, m_swap_done);
            check("s_waitrequest", s_waitrequest, (m_clr > 0));
            check("s_readdatavalid", s_readdatavalid, m_rdv);
            check("scan_valid", scan_valid, m_sv);
            if (m_rd_known) check("s_readdata", s_readdata, m_rd);
            if (m_sd_known) check("scan_data", scan_data, m_sd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        s_chipselect = 1'b0; s_write = 1'b0; s_read = 1'b0;
        swap_req = 1'b0; frame_start = 1'b0; scan_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d; s_byteenable = be;
        step();
        idle_inputs();
        $display("write addr=0x%0h data=0x%0h be=%b", a, d, be);
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
        step();
        idle_inputs();
        check("read_latency", s_readdatavalid, 1'b1);
        d = s_readdata;
        $display("read  addr=0x%0h data=0x%0h", a, d);
    endtask

    task automatic scan_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        scan_en = 1'b1; scan_addr = a;
        step();
        idle_inputs();
        check("scan_latency", scan_valid, 1'b1);
        d = scan_data;
        $display("scan  addr=0x%0h data=0x%0h", a, d);
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (s_waitrequest && n < 200) begin
            n++;
            step();
        end
        if (n >= 200) check("clear_timeout", 32'(n), 32'd0);
    endtask

    // Guards against a hang. Nothing in the bench depends on it.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] d;
        int n;
        reset = 1'b1; s_address = '0; s_byteenable = 2'b11; s_writedata = '0; scan_addr = '0;
        idle_inputs();
        step(); step();
        reset = 1'b0;
        step();
        check("reset_front_sel", front_sel, 1'b0);
        check("reset_readdata", s_readdata, 16'h0000);
        check("reset_scan_data", scan_data, 16'h0000);
        check("reset_waitrequest", s_waitrequest, 1'b0);
        check("reset_swap_done", swap_done, 1'b0);

        // Write and read back in the back bank. The front bank must not see the data.
        cpu_write(AW'(5), 16'hBEEF, 2'b11);
        cpu_read(AW'(5), d);
        check("read_beef", d, 16'hBEEF);
        check("model_rd_beef", m_rd, 16'hBEEF);
        scan_read(AW'(5), d);
        check("scan_no_beef_before_swap", (d != 16'hBEEF), 1'b1);

        // Partial byte write: only the upper lane changes.
        cpu_write(AW'(5), 16'h1234, 2'b10);
        cpu_read(AW'(5), d);
        check("byteenable_merge", d, 16'h12EF);
        cpu_write(AW'(5), 16'h0000, 2'b00);
        cpu_read(AW'(5), d);
        check("byteenable_none", d, 16'h12EF);

        // Read and write together is a write only.
        s_chipselect = 1'b1; s_write = 1'b1; s_read = 1'b1; s_address = AW'(7);
        s_writedata = 16'h5A5A; s_byteenable = 2'b11;
        step();
        idle_inputs();
        check("rw_no_valid", s_readdatavalid, 1'b0);
        cpu_read(AW'(7), d);
        check("rw_is_write", d, 16'h5A5A);
        cpu_write(AW'(5), 16'hBEEF, 2'b11);

        // Swap request, then idle cycles (one with a second request), then frame_start.
        swap_req = 1'b1; step(); swap_req = 1'b0;
        step();
        swap_req = 1'b1; step(); swap_req = 1'b0;
        step();
        check("pending_no_toggle", front_sel, 1'b0);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("swap_front_sel", front_sel, 1'b1);
        check("swap_done_pulse", swap_done, 1'b1);
        $display("swap  front_sel=%0d swap_done=%0d", front_sel, swap_done);
        wait_clear(n);
        check("clear_cycles", 32'(n), CLR ? 32'(DEPTH) : 32'd0);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("single_toggle", front_sel, 1'b1);
        scan_read(AW'(5), d);
        check("scan_beef_after_swap", d, 16'hBEEF);

        // After a clear, the new back bank reads back as zero.
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                cpu_read(AW'(i), d);
                check("cleared_word", d, 16'h0000);
            end
        end
        cpu_write(AW'(3), 16'hA5C3, 2'b11);
        cpu_write(AW'(DEPTH - 1), 16'h0F0F, 2'b01);
        cpu_write(AW'(DEPTH - 1), 16'hF0F0, 2'b10);
        cpu_read(AW'(3), d);
        check("bank0_addr3", d, 16'hA5C3);
        cpu_read(AW'(DEPTH - 1), d);
        check("bank0_top_addr", d, 16'hF00F);

        // swap_req and frame_start together swap on the next edge.
        swap_req = 1'b1; frame_start = 1'b1; step(); idle_inputs();
        check("sameclk_front_sel", front_sel, 1'b0);
        check("sameclk_swap_done", swap_done, 1'b1);
        wait_clear(n);
        scan_read(AW'(3), d);
        check("scan_bank0_addr3", d, 16'hA5C3);

        // Move to front=1, then go to PENDING, then reset with a read in flight.
        swap_req = 1'b1; frame_start = 1'b1; step(); idle_inputs();
        wait_clear(n);
        check("pre_reset_front", front_sel, 1'b1);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        s_chipselect = 1'b1; s_read = 1'b1; s_address = AW'(5); reset = 1'b1;
        step();
        idle_inputs();
        check("reset_front_zero", front_sel, 1'b0);
        check("reset_no_valid", s_readdatavalid, 1'b0);
        reset = 1'b0;
        step();
        check("reset_no_late_valid", s_readdatavalid, 1'b0);
        frame_start = 1'b1; step(); frame_start = 1'b0;
        check("reset_state_idle", front_sel, 1'b0);
        check("reset_no_swap_done", swap_done, 1'b0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
